fetch_word_cache: RTL

//  Responder end of the generic_bus_if instruction-fetch port. Sits between the RV32C

---
 rtl/fetch_cache_pkg.sv | 45 ++++
 rtl/generic_bus_if.sv | 33 +++
 rtl/fetch_word_cache.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_cache_pkg.sv
// ---------------------------------------------------------------------------
// fetch_cache_pkg
//   Shared types and helpers for the instruction-fetch word cache.
//   - fc_state_t : controller state (IDLE serves hits, FILL waits on memory)
//   - fc_line_t  : one cache line (valid marker, tag, 32-bit instruction word)
//   - get_idx / get_tag : split a byte address into set index and tag for a
//     cache of 2**idx_w one-word lines.
//   The tag field is sized for the smallest legal cache (two lines) at the
//   widest supported address, so every legal geometry fits in it.
//   Tags are stored zero-extended.
// ---------------------------------------------------------------------------
package fetch_cache_pkg;

  localparam int FC_NSETS  = 16;
  localparam int FC_ADDR_W = 32;
  localparam int FC_TAG_W  = FC_ADDR_W - 3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fc_state_t;

  typedef struct packed {
    logic                valid;
    logic [FC_TAG_W-1:0] tag;
    logic [31:0]         data;
  } fc_line_t;

  // Set index: word address bits just above the byte offset.
  function automatic logic [FC_ADDR_W-1:0] get_idx(input logic [FC_ADDR_W-1:0] addr,
                                                   input int unsigned idx_w);
    logic [FC_ADDR_W-1:0] mask;
    mask = (FC_ADDR_W'(1) << idx_w) - FC_ADDR_W'(1);
    return (addr >> 2) & mask;
  endfunction

  // Tag: everything above the index, zero-extended into the line's tag field.
  function automatic logic [FC_TAG_W-1:0] get_tag(input logic [FC_ADDR_W-1:0] addr,
                                                  input int unsigned idx_w);
    logic [FC_ADDR_W-1:0] shifted;
    shifted = addr >> (2 + idx_w);
    return shifted[FC_TAG_W-1:0];
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// ---------------------------------------------------------------------------
// generic_bus_if
//   Simple single-word bus used between the fetch buffer, the fetch cache
//   and memory.
//   Handshake: the initiator holds ren (or wen) and addr steady. The
//   transfer completes in the cycle where the responder drives busy=0.
//   rdata is valid only in that cycle. busy=1 means "not done this cycle",
//   whether or not a request is present.
//   Modports:
//     generic_bus : responder side (drives rdata, busy)
//     cpu         : initiator side (drives ren, wen, addr, wdata, byte_en)
// ---------------------------------------------------------------------------
interface generic_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              ren;
  logic              wen;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [3:0]        byte_en;

  modport generic_bus (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );

  modport cpu (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/fetch_word_cache.sv
// ---------------------------------------------------------------------------
// fetch_word_cache
//   Direct-mapped, read-only, one-word-per-line instruction cache placed
//   between the fetch buffer (cpu port) and the memory bus (mem port).
//   A hit answers in the same cycle. A miss issues one single-word read
//   downstream, installs the word, and then lets the held request hit from
//   IDLE on the following cycle.
//   Ports:
//     CLK        : clock, all state on rising edge
//     nRST       : asynchronous active-low reset
//     flush      : invalidate every line (fence.i / redirect)
//     flush_done : one-cycle pulse in the cycle after flush is seen
//     state      : current controller state, for debug/observation
//     cpu        : responder port toward the fetch buffer
//     mem        : initiator port toward memory
// ---------------------------------------------------------------------------
module fetch_word_cache
  import fetch_cache_pkg::*;
#(
  parameter int NSETS  = FC_NSETS,
  parameter int ADDR_W = FC_ADDR_W
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  output logic               flush_done,
  output fc_state_t          state,
  generic_bus_if.generic_bus cpu,
  generic_bus_if.cpu         mem
);

  localparam int IDX_W = $clog2(NSETS);

  fc_state_t         state_q;
  fc_state_t         state_d;
  logic [NSETS-1:0]  valid;
  fc_line_t          lines [NSETS];
  logic [ADDR_W-1:0] fill_addr;
  logic              flush_pend;

  logic [IDX_W-1:0]    req_idx;
  logic [FC_TAG_W-1:0] req_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [FC_TAG_W-1:0] fill_tag;
  logic                hit;
  logic                start_fill;
  logic                fill_done;
  logic                install;

  // Writes are not supported, so wdata/byte_en from the fetch side are ignored.
  logic unused_bits;
  assign unused_bits = ^{cpu.wdata, cpu.byte_en};

  assign req_idx  = IDX_W'(get_idx(FC_ADDR_W'(cpu.addr), IDX_W));
  assign req_tag  = get_tag(FC_ADDR_W'(cpu.addr), IDX_W);
  assign fill_idx = IDX_W'(get_idx(FC_ADDR_W'(fill_addr), IDX_W));
  assign fill_tag = get_tag(FC_ADDR_W'(fill_addr), IDX_W);

  // The valid vector gates everything, so it alone is what flush clears.
  // The per-line valid marks storage that has been written at least once.
  assign hit = valid[req_idx] && lines[req_idx].valid && (lines[req_idx].tag == req_tag);

  assign fill_done = (state_q == FILL) && !mem.busy;
  // A fill that saw a flush at any point during its flight is stale.
  assign install   = fill_done && !flush && !flush_pend;

  assign state = state_q;

  // Downstream side: one read outstanding at most, never a write.
  assign mem.ren     = (state_q == FILL);
  assign mem.wen     = 1'b0;
  assign mem.addr    = (state_q == FILL) ? fill_addr : '0;
  assign mem.wdata   = '0;
  assign mem.byte_en = 4'hF;

  always_comb begin
    state_d    = state_q;
    cpu.busy   = 1'b1;
    cpu.rdata  = '0;
    start_fill = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu.ren) begin
          // flush wins over a hit: the line is about to be invalidated.
          if (hit && !flush) begin
            cpu.busy  = 1'b0;
            cpu.rdata = lines[req_idx].data;
          end else begin
            start_fill = 1'b1;
            state_d    = FILL;
          end
        end else if (cpu.wen) begin
          // Acknowledge and drop the write so the initiator cannot stall.
          cpu.busy = 1'b0;
        end
      end
      FILL: begin
        // Fill data is never forwarded. The request re-evaluates in IDLE.
        if (!mem.busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      fill_addr  <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      valid      <= '0;
    end else begin
      state_q    <= state_d;
      flush_done <= flush;

      if (start_fill) begin
        fill_addr <= {cpu.addr[ADDR_W-1:2], 2'b00};
      end

      if (fill_done) begin
        flush_pend <= 1'b0;
      end else if (flush && (state_q == FILL)) begin
        flush_pend <= 1'b1;
      end

      if (flush) begin
        valid <= '0;
      end else if (install) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Line storage needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge CLK) begin
    if (install) begin
      lines[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: mem.rdata};
    end
  end

endmodule
